selector_campo_ajuste: RTL and testbench
========================================

SELECTOR_CAMPO_AJUSTE -- requirements
Module: selector_campo_ajuste

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 1000000, meaning the number of clk cycles a raw button level must stay stable before it is accepted (10 ms at 100 MHz).
REQ-002 The module SHALL have parameter TIMEOUT, default 1000000000, meaning the number of idle clk cycles in program mode before automatic exit (10 s).
REQ-003 The module SHALL have parameter NUM_FIELDS, default 9, meaning the highest field code.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have ports btn_prog, btn_left, btn_right, btn_up and btn_down, each input, 1 bit: raw asynchronous active-high pushbuttons.
REQ-007 The module SHALL have port en_count, output, 4 bits: selected field code, 0 = none, 1..NUM_FIELDS = field under adjustment.
REQ-008 The module SHALL have port enUP, output, 1 bit: level, increment request for the selected field.
REQ-009 The module SHALL have port enDOWN, output, 1 bit: level, decrement request for the selected field.
REQ-010 The module SHALL have port prog_mode, output, 1 bit: high while in program mode.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized button SHALL have its own debounce counter: the debounced level SHALL take the synchronized value after that value differs from it for DB_CYCLES consecutive cycles; any return to the old value SHALL clear the counter.
REQ-013 A press event SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; releases SHALL generate no event.
REQ-014 The FSM SHALL have exactly two states, IDLE and PROG, and SHALL hold a 4-bit field register.
REQ-015 In IDLE: en_count = 0, prog_mode = 0, enUP = enDOWN = 0, and left/right/up/down events SHALL be ignored.
REQ-016 In IDLE, a btn_prog event SHALL move the FSM to PROG and load field = 1 on the same edge.
REQ-017 In PROG: en_count = field and prog_mode = 1.
REQ-018 In PROG, a btn_prog event SHALL return the FSM to IDLE and SHALL take priority over any left/right event in the same cycle.
REQ-019 In PROG, a right event SHALL set field to field+1, wrapping from NUM_FIELDS to 1.
REQ-020 In PROG, a left event SHALL set field to field-1, wrapping from 1 to NUM_FIELDS.
REQ-021 Simultaneous left and right events SHALL leave field unchanged.
REQ-022 In PROG, enUP SHALL equal debounced up AND NOT debounced down, registered with 1-cycle latency.
REQ-023 In PROG, enDOWN SHALL equal debounced down AND NOT debounced up, registered with 1-cycle latency.
REQ-024 As a consequence of REQ-022 and REQ-023, enUP and enDOWN SHALL never be high together.
REQ-025 On any transition to IDLE, enUP and enDOWN SHALL be 0 from the cycle after the transition.
REQ-026 A 30-bit idle counter SHALL clear on entering PROG, on any press event, and on every cycle either debounced up or down is high; it SHALL increment otherwise while in PROG.
REQ-027 When the idle counter reaches TIMEOUT-1 and would increment again, the FSM SHALL enter IDLE.
REQ-028 The field value SHALL be retained in IDLE but SHALL be reloaded to 1 on the next entry to PROG.
REQ-029 en_count SHALL never present a value outside 0..NUM_FIELDS.

Reset
REQ-030 While reset is high on a clk edge, the following SHALL be cleared: synchronizers, debounce counters, debounced levels (0), idle counter (0), state (IDLE) and field (1).
REQ-031 From the first cycle after reset, outputs SHALL read en_count = 0, enUP = 0, enDOWN = 0 and prog_mode = 0.
REQ-032 Reset asserted mid-operation SHALL override all pending events.
REQ-033 A button held through reset deassertion SHALL yield a press event DB_CYCLES+2 cycles later, with no earlier event.

Verification (DB_CYCLES=4, TIMEOUT=100, NUM_FIELDS=9)
REQ-034 A bench SHALL cover: reset held 3 cycles with all buttons high -> outputs 0 during reset; btn_prog event about 6 cycles after release -> prog_mode = 1, en_count = 1.
REQ-035 A bench SHALL cover: btn_right pulsed 2 cycles (bounce) -> no field change; btn_right held 10 cycles, 9 times -> en_count runs 2..9 then 1.
REQ-036 A bench SHALL cover: at field 1, one left press -> en_count = 9; left and right debounced on the same cycle -> en_count unchanged.
REQ-037 A bench SHALL cover: btn_up held in PROG -> enUP = 1 one cycle after debounced up; btn_down added -> enUP = 0, enDOWN = 0; btn_up released -> enDOWN = 1.
REQ-038 A bench SHALL cover: in PROG with no activity for 100 cycles -> en_count = 0, prog_mode = 0; btn_up held throughout instead -> no timeout.
REQ-039 A bench SHALL cover: btn_prog and btn_right events in the same cycle in PROG -> IDLE, and the next entry to PROG shows en_count = 1.

Source files
------------

// File: rtl/selector_campo_ajuste.sv
// selector_campo_ajuste: pushbutton-driven field selector for a settings menu.
//   Five raw buttons are synchronized, debounced and edge-detected; a two-state FSM
//   (IDLE/PROG) walks a field index and issues level up/down adjust requests.
// Ports: clk, reset (sync, active-high); btn_prog/left/right/up/down (raw, async);
//   en_count (0 = none, 1..NUM_FIELDS), enUP, enDOWN (registered levels), prog_mode.
module selector_campo_ajuste #(
  parameter int DB_CYCLES  = 1000000,
  parameter int TIMEOUT    = 1000000000,
  parameter int NUM_FIELDS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       prog_mode
);

  localparam int B_PROG  = 0;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 2;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 4;

  localparam int              DBW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [29:0]     IDLE_LAST = 30'(TIMEOUT - 1);
  localparam logic [3:0]      FIELD_MAX = 4'(NUM_FIELDS);

  typedef enum logic {IDLE, PROG} state_t;

  logic [4:0]     raw;
  logic [4:0]     sync1;
  logic [4:0]     sync2;
  logic [4:0]     deb;
  logic [4:0]     deb_q;
  logic [4:0]     press;
  logic [DBW-1:0] db_cnt [5];

  state_t      state, state_nx;
  logic [3:0]  field, field_nx;
  logic [29:0] idle_cnt, idle_cnt_nx;
  logic        en_up_nx, en_down_nx;
  logic        activity;

  assign raw = {btn_down, btn_up, btn_right, btn_left, btn_prog};

  // Synchronizer, per-button debounce and previous debounced level for edge detect.
  // The counter measures how long the synchronized input has disagreed with the
  // accepted level; any agreement restarts the measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // One-cycle pulse on debounced rising edges only.
  assign press = deb & ~deb_q;

  // Anything that should keep program mode alive: a new press, or up/down held.
  assign activity = (|press) | deb[B_UP] | deb[B_DOWN];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      field    <= 4'd1;
      idle_cnt <= '0;
      enUP     <= 1'b0;
      enDOWN   <= 1'b0;
    end else begin
      state    <= state_nx;
      field    <= field_nx;
      idle_cnt <= idle_cnt_nx;
      enUP     <= en_up_nx;
      enDOWN   <= en_down_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    field_nx    = field;
    idle_cnt_nx = '0;
    case (state)
      IDLE: begin
        if (press[B_PROG]) begin
          state_nx = PROG;
          field_nx = 4'd1;
        end
      end
      PROG: begin
        if (press[B_PROG]) begin
          // Leaving wins over any simultaneous left/right.
          state_nx = IDLE;
        end else if (activity) begin
          if (press[B_RIGHT] && !press[B_LEFT]) begin
            field_nx = (field >= FIELD_MAX) ? 4'd1 : field + 4'd1;
          end else if (press[B_LEFT] && !press[B_RIGHT]) begin
            field_nx = (field <= 4'd1) ? FIELD_MAX : field - 4'd1;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          state_nx = IDLE;
        end else begin
          idle_cnt_nx = idle_cnt + 30'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Gated by the next state so the adjust levels drop together with the exit.
    en_up_nx   = (state_nx == PROG) && deb[B_UP] && !deb[B_DOWN];
    en_down_nx = (state_nx == PROG) && deb[B_DOWN] && !deb[B_UP];
  end

  assign prog_mode = (state == PROG);
  assign en_count  = (state == PROG) ? field : 4'd0;

endmodule

// File: tb/tb_selector_campo_ajuste.sv
module tb_selector_campo_ajuste;

  localparam int DB = 4;
  localparam int TO = 100;
  localparam int NF = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_prog = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [3:0] en_count;
  logic       enUP, enDOWN, prog_mode;

  int n_checks = 0;
  int n_pass   = 0;

  selector_campo_ajuste #(.DB_CYCLES(DB), .TIMEOUT(TO), .NUM_FIELDS(NF)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_prog  (btn_prog),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .en_count  (en_count),
    .enUP      (enUP),
    .enDOWN    (enDOWN),
    .prog_mode (prog_mode)
  );

  always #5 clk = ~clk;

  wire [6:0] dut_out = {en_count, enUP, enDOWN, prog_mode};

  // Reference model. Button order: 0 prog, 1 left, 2 right, 3 up, 4 down.
  // The synchronized stream is the raw input seen two edges earlier; a level is
  // accepted once that stream has held a new value for DB consecutive edges.
  bit   m_d1 [5], m_d2 [5], m_last [5], m_deb [5], m_debo [5];
  int   m_run [5];
  bit   m_mode, m_eu, m_ed;
  int   m_field, m_idle;
  logic [6:0] m_out = '0;

  always @(posedge clk) begin
    bit [4:0] rawv;
    bit [4:0] ev;
    bit       s;
    rawv = {btn_down, btn_up, btn_right, btn_left, btn_prog};
    if (reset) begin
      for (int b = 0; b < 5; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_last[b] = 0; m_deb[b] = 0; m_debo[b] = 0; m_run[b] = 0;
      end
      m_mode = 0; m_field = 1; m_idle = 0; m_eu = 0; m_ed = 0;
    end else begin
      for (int b = 0; b < 5; b++) ev[b] = m_deb[b] && !m_debo[b];
      if (!m_mode) begin
        if (ev[0]) begin m_mode = 1; m_field = 1; m_idle = 0; end
      end else if (ev[0]) begin
        m_mode = 0;
      end else if ((ev != 0) || m_deb[3] || m_deb[4]) begin
        m_idle = 0;
        if (ev[2] && !ev[1])      m_field = m_field % NF + 1;
        else if (ev[1] && !ev[2]) m_field = (m_field + NF - 2) % NF + 1;
      end else if (m_idle == TO - 1) begin
        m_mode = 0;
      end else begin
        m_idle++;
      end
      m_eu = m_mode && m_deb[3] && !m_deb[4];
      m_ed = m_mode && m_deb[4] && !m_deb[3];
      for (int b = 0; b < 5; b++) begin
        m_debo[b] = m_deb[b];
        s = m_d2[b];
        if (s == m_last[b]) begin
          if (m_run[b] < 1000) m_run[b]++;
        end else begin
          m_run[b] = 1;
        end
        m_last[b] = s;
        if (s != m_deb[b] && m_run[b] >= DB) m_deb[b] = s;
        m_d2[b] = m_d1[b];
        m_d1[b] = rawv[b];
      end
    end
    m_out = {m_mode ? 4'(m_field) : 4'd0, m_eu, m_ed, m_mode};
  end

  task automatic set_btn(input logic p, input logic l, input logic r, input logic u, input logic d);
    btn_prog = p; btn_left = l; btn_right = r; btn_up = u; btn_down = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_btn(1, 1, 1, 1, 1);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (dut_out !== 7'd0) $display("FAIL reset_outputs: got %b want %b", dut_out, 7'd0);
      else n_pass++;
    end
    reset = 1'b0;
    set_btn(1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({en_count, prog_mode} !== ((k >= 7) ? 5'b0001_1 : 5'b0000_0))
        $display("FAIL reset_prog_entry cyc %0d: got en_count=%0d prog=%b want prog=%b", k, en_count, prog_mode, k >= 7);
      else n_pass++;
      n_checks++;
      if (dut_out !== m_out) $display("FAIL reset_model cyc %0d: got %b want %b", k, dut_out, m_out);
      else n_pass++;
    end
    set_btn(0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_right();
    set_btn(0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    set_btn(0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (en_count !== 4'd1) $display("FAIL right_bounce: got en_count=%0d want 1", en_count);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 20; k++) begin
        set_btn(0, 0, k < 10, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut_out !== m_out) $display("FAIL right_model press %0d cyc %0d: got %b want %b", i, k, dut_out, m_out);
        else n_pass++;
      end
      n_checks++;
      if (en_count !== 4'((i + 1) % 9 + 1))
        $display("FAIL right_step %0d: got en_count=%0d want %0d", i, en_count, (i + 1) % 9 + 1);
      else n_pass++;
    end
  endtask

  task automatic test_left_wrap();
    for (int k = 0; k < 20; k++) begin
      set_btn(0, k < 10, 0, 0, 0);
      @(negedge clk);
    end
    n_checks++;
    if (en_count !== 4'd9) $display("FAIL left_wrap: got en_count=%0d want 9", en_count);
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      set_btn(0, k < 10, k < 10, 0, 0);
      @(negedge clk);
      n_checks++;
      if (dut_out !== m_out) $display("FAIL left_right_model cyc %0d: got %b want %b", k, dut_out, m_out);
      else n_pass++;
    end
    n_checks++;
    if (en_count !== 4'd9) $display("FAIL left_right_same: got en_count=%0d want 9", en_count);
    else n_pass++;
  endtask

  task automatic test_updown();
    set_btn(0, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (enUP !== (k >= 7)) $display("FAIL up_latency cyc %0d: got enUP=%b want %b", k, enUP, k >= 7);
      else n_pass++;
    end
    set_btn(0, 0, 0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_out !== m_out) $display("FAIL updown_model cyc %0d: got %b want %b", k, dut_out, m_out);
      else n_pass++;
    end
    n_checks++;
    if ({enUP, enDOWN} !== 2'b00) $display("FAIL up_and_down: got enUP=%b enDOWN=%b want 0 0", enUP, enDOWN);
    else n_pass++;
    set_btn(0, 0, 0, 0, 1);
    repeat (8) @(negedge clk);
    n_checks++;
    if ({enUP, enDOWN} !== 2'b01) $display("FAIL down_only: got enUP=%b enDOWN=%b want 0 1", enUP, enDOWN);
    else n_pass++;
    set_btn(0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    n_checks++;
    if ({enUP, enDOWN, prog_mode} !== 3'b001) $display("FAIL updown_release: got %b want 001", {enUP, enDOWN, prog_mode});
    else n_pass++;
  endtask

  task automatic test_timeout();
    set_btn(0, 0, 0, 1, 0);
    repeat (150) @(negedge clk);
    n_checks++;
    if (prog_mode !== 1'b1) $display("FAIL timeout_held_up: got prog_mode=%b want 1", prog_mode);
    else n_pass++;
    set_btn(0, 0, 0, 0, 0);
    for (int k = 1; k <= 106; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_out !== m_out) $display("FAIL timeout_model cyc %0d: got %b want %b", k, dut_out, m_out);
      else n_pass++;
      if (k == 105) begin
        n_checks++;
        if (prog_mode !== 1'b1) $display("FAIL timeout_early: got prog_mode=%b want 1", prog_mode);
        else n_pass++;
      end
    end
    n_checks++;
    if ({en_count, prog_mode} !== 5'd0) $display("FAIL timeout_exit: got en_count=%0d prog=%b want 0 0", en_count, prog_mode);
    else n_pass++;
  endtask

  task automatic test_prog_priority();
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 20; k++) begin
        // phases: enter, step right, prog+right together, enter again
        set_btn(k < 10 && ph != 1, 0, k < 10 && (ph == 1 || ph == 2), 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut_out !== m_out) $display("FAIL prio_model ph %0d cyc %0d: got %b want %b", ph, k, dut_out, m_out);
        else n_pass++;
      end
      if (ph == 1) begin
        n_checks++;
        if (en_count !== 4'd2) $display("FAIL prio_setup: got en_count=%0d want 2", en_count);
        else n_pass++;
      end
      if (ph == 2) begin
        n_checks++;
        if (prog_mode !== 1'b0) $display("FAIL prio_exit: got prog_mode=%b want 0", prog_mode);
        else n_pass++;
      end
    end
    n_checks++;
    if ({en_count, prog_mode} !== 5'b0001_1) $display("FAIL prio_reload: got en_count=%0d prog=%b want 1 1", en_count, prog_mode);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_btn(0, 0, 1, 0, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_out !== 7'd0) $display("FAIL reset_mid: got %b want 0", dut_out);
    else n_pass++;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    set_btn(0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (dut_out !== 7'd0) $display("FAIL reset_mid_after: got %b want 0", dut_out);
    else n_pass++;
  endtask

  task automatic test_random();
    int   hold [5];
    logic lvl [5];
    for (int b = 0; b < 5; b++) begin hold[b] = 0; lvl[b] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = (b == 0) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 14);
        end
        hold[b]--;
      end
      set_btn(lvl[0], lvl[1], lvl[2], lvl[3], lvl[4]);
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
      n_checks++;
      if (dut_out !== m_out) $display("FAIL random_model cyc %0d: got %b want %b", c, dut_out, m_out);
      else n_pass++;
      n_checks++;
      if (en_count > 4'd9 || (enUP && enDOWN))
        $display("FAIL random_invariant cyc %0d: got en_count=%0d enUP=%b enDOWN=%b", c, en_count, enUP, enDOWN);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_right();
    test_left_wrap();
    test_updown();
    test_timeout();
    test_prog_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
